onehot_seq_2_4: RTL

Sequenced 2-to-4 one-hot decoder: the receive-side counterpart of the 4-to-2 priority encoder. It accepts encoded words {decode[1:0], legal} over a valid/ready handshake and drives the four select lines s1..s4 one-hot for a fixed hold time, followed by a fixed all-zero gap. A one-entry pending register allows back-to-back words without idle cycles. It sits between the select-encoding logic and the downstream strobe/enable fabric.

---
 rtl/onehot_seq_pkg.sv | 13 +
 rtl/onehot_seq_2_4_dec.sv | 11 +
 rtl/onehot_seq_2_4.sv | 103 ++++++++++
 3 files changed

// File: rtl/onehot_seq_pkg.sv
// onehot_seq_pkg: shared types and constants for the sequenced 2-to-4 one-hot decoder
package onehot_seq_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;
  localparam logic [1:0] CODE_S1 = 2'b00;
  localparam logic [1:0] CODE_S2 = 2'b01;
  localparam logic [1:0] CODE_S3 = 2'b10;
  localparam logic [1:0] CODE_S4 = 2'b11;
  localparam int CNT_W = 8;
  typedef struct packed {
    logic [1:0] decode;
    logic       legal;
  } word_t;
endpackage

// File: rtl/onehot_seq_2_4_dec.sv
// dec_2_4_onehot: combinational {decode, legal} to one-hot {s4, s3, s2, s1}
module dec_2_4_onehot
  import onehot_seq_pkg::*;
(
  input  logic [1:0] decode,
  input  logic       legal,
  output logic [3:0] sel
);
  always_comb
    sel = legal ? {decode == CODE_S4, decode == CODE_S3, decode == CODE_S2, decode == CODE_S1} : 4'b0000;
endmodule

// File: rtl/onehot_seq_2_4.sv
// onehot_seq_2_4: handshaked 2-to-4 decoder holding each select for HOLD_CYCLES,
// then GAP_CYCLES of zeros, with a one-entry pending register for back-to-back words
module onehot_seq_2_4
  import onehot_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] decode,
  input  logic       legal,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       s4,
  output logic       busy,
  output logic       done
);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t            act_q, act_d, pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [3:0]       sel_q, sel_d, dec_sel;
  logic             busy_q, busy_d, done_q, done_d;
  logic             xfer, nxt;
  word_t            in_word;
  assign in_word = '{decode: decode, legal: legal};
  assign xfer = in_valid && !pend_valid_q;
  dec_2_4_onehot u_dec (
    .decode (act_d.decode),
    .legal  (act_d.legal),
    .sel    (dec_sel)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    act_d = act_q;
    pend_d = pend_q;
    pend_valid_d = pend_valid_q;
    nxt = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          act_d = in_word;
          cnt_d = HOLD_LD;
          state_d = HOLD;
        end
      end
      HOLD, GAP: begin
        if (xfer) begin
          pend_d = in_word;
          pend_valid_d = 1'b1;
        end
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (state_q == HOLD && GAP_CYCLES > 0) begin
          state_d = GAP;
          cnt_d = GAP_LD;
        end else nxt = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A word arriving in the slot-ending cycle starts straight away so no idle cycle is inserted
    if (nxt) begin
      state_d = (pend_valid_q || xfer) ? HOLD : IDLE;
      cnt_d = (pend_valid_q || xfer) ? HOLD_LD : '0;
      act_d = pend_valid_q ? pend_q : xfer ? in_word : act_q;
      pend_valid_d = 1'b0;
    end
    sel_d = (state_d == HOLD) ? dec_sel : 4'b0000;
    busy_d = state_d != IDLE;
    done_d = state_d == HOLD && cnt_d == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      act_q <= '0;
      pend_q <= '0;
      pend_valid_q <= 1'b0;
      sel_q <= 4'b0000;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
      pend_q <= pend_d;
      pend_valid_q <= pend_valid_d;
      sel_q <= sel_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign {s4, s3, s2, s1} = sel_q;
  assign busy = busy_q;
  assign done = done_q;
  assign in_ready = ~pend_valid_q;
endmodule
